// File: rtl/ucode_ind_seq_pkg.sv
// Shared microcode index-sequencer encodings: index modes and sequencer states.
package ucode_ind_seq_pkg;

  typedef enum logic [1:0] {
    ModeRaw     = 2'b00,
    ModeByteInc = 2'b01,
    ModeWordInc = 2'b10,
    ModePair    = 2'b11
  } ind_mode_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StPair2 = 1'b1
  } ind_state_e;

  localparam int unsigned StateWidth = 1;

  localparam logic [1:0] NumFirst  = 2'd0;
  localparam logic [1:0] NumSecond = 2'd1;

endpackage

// File: rtl/ucode_ind_seq_if.sv
// Decode/E-stage handshake between the microcode decoder and the index sequencer.
interface ucode_ind_seq_if;

  logic       ind_start_r;
  logic [1:0] ind_mode_r;
  logic       iu_hold_e;
  logic       iu_kill_e;
  logic       sel_wd_inc_r;
  logic       sel_offset_add1_r;
  logic       ind_busy_r;
  logic       ind_valid_e;
  logic [1:0] ind_num_e;
  logic       ind_last_e;

  // Decode/pipeline side.
  modport master (
    output ind_start_r, ind_mode_r, iu_hold_e, iu_kill_e,
    input  sel_wd_inc_r, sel_offset_add1_r, ind_busy_r,
    input  ind_valid_e, ind_num_e, ind_last_e
  );

  // Sequencer side.
  modport slave (
    input  ind_start_r, ind_mode_r, iu_hold_e, iu_kill_e,
    output sel_wd_inc_r, sel_offset_add1_r, ind_busy_r,
    output ind_valid_e, ind_num_e, ind_last_e
  );

endinterface

// File: rtl/ucode_ind_seq_dffre.sv
// Codebase flop cell: synchronous active-low reset with load enable; reset wins.
module ucode_ind_seq_dffre #(
  parameter int unsigned     Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      q <= ResetVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ucode_ind_seq.sv
// Microcode index sequencer: steers index-register selects and tracks one- or
// two-index ops (PAIR) through the E stage.
module ucode_ind_seq
  import ucode_ind_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset_l,
  input  logic            sm,
  input  logic            sin,
  output logic            so,
  ucode_ind_seq_if.slave  bus
);

  ind_state_e            state_q, state_d;
  logic [StateWidth-1:0] state_raw;
  logic                  valid_q, valid_d;
  logic [1:0]            num_q, num_d;
  logic                  last_q, last_d;
  logic                  capture;
  logic                  hold_en;
  logic                  ord_en;
  ind_mode_e             mode;

  assign mode = ind_mode_e'(bus.ind_mode_r);

  // Capture: an unheld, unkilled cycle that has an index to load.
  assign capture = !bus.iu_kill_e && !bus.iu_hold_e &&
                   ((state_q == StPair2) || bus.ind_start_r);
  assign hold_en = bus.iu_kill_e || !bus.iu_hold_e;
  assign ord_en  = bus.iu_kill_e || capture;

  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    num_d   = NumFirst;
    last_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.ind_start_r && !bus.iu_hold_e) begin
          valid_d = 1'b1;
          num_d   = NumFirst;
          last_d  = (mode != ModePair);
          state_d = (mode == ModePair) ? StPair2 : StIdle;
        end
      end
      StPair2: begin
        if (!bus.iu_hold_e) begin
          valid_d = 1'b1;
          num_d   = NumSecond;
          last_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.iu_kill_e) begin
      state_d = StIdle;
      valid_d = 1'b0;
      num_d   = NumFirst;
      last_d  = 1'b0;
    end
  end

  // Selects and busy are forced low while reset is asserted.
  always_comb begin
    bus.sel_wd_inc_r      = 1'b0;
    bus.sel_offset_add1_r = 1'b0;
    bus.ind_busy_r        = 1'b0;
    if (reset_l) begin
      unique case (state_q)
        StIdle: begin
          if (bus.ind_start_r) begin
            unique case (mode)
              ModeRaw: begin
                bus.sel_wd_inc_r      = 1'b0;
                bus.sel_offset_add1_r = 1'b0;
              end
              ModeByteInc: begin
                bus.sel_wd_inc_r      = 1'b0;
                bus.sel_offset_add1_r = 1'b1;
              end
              ModeWordInc: begin
                bus.sel_wd_inc_r      = 1'b1;
                bus.sel_offset_add1_r = 1'b1;
              end
              ModePair: begin
                bus.sel_wd_inc_r      = 1'b0;
                bus.sel_offset_add1_r = 1'b0;
              end
              default: ;
            endcase
          end
        end
        StPair2: begin
          bus.sel_wd_inc_r      = 1'b1;
          bus.sel_offset_add1_r = 1'b1;
          bus.ind_busy_r        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  ucode_ind_seq_dffre #(
    .Width    (StateWidth),
    .ResetVal (StIdle)
  ) u_state_ff (
    .clk     (clk),
    .reset_l (reset_l),
    .en      (hold_en),
    .d       (state_d),
    .q       (state_raw)
  );

  assign state_q = ind_state_e'(state_raw);

  ucode_ind_seq_dffre #(
    .Width    (1),
    .ResetVal (1'b0)
  ) u_valid_ff (
    .clk     (clk),
    .reset_l (reset_l),
    .en      (hold_en),
    .d       (valid_d),
    .q       (valid_q)
  );

  ucode_ind_seq_dffre #(
    .Width    (2),
    .ResetVal (2'd0)
  ) u_num_ff (
    .clk     (clk),
    .reset_l (reset_l),
    .en      (ord_en),
    .d       (num_d),
    .q       (num_q)
  );

  ucode_ind_seq_dffre #(
    .Width    (1),
    .ResetVal (1'b0)
  ) u_last_ff (
    .clk     (clk),
    .reset_l (reset_l),
    .en      (ord_en),
    .d       (last_d),
    .q       (last_q)
  );

  assign bus.ind_valid_e = valid_q;
  assign bus.ind_num_e   = num_q;
  assign bus.ind_last_e  = last_q;

  // Scan chain is stitched at insertion; functionally so mirrors state bit 0.
  assign so = state_raw[0];

  logic unused_scan;
  assign unused_scan = sm ^ sin;

endmodule

// File: doc/ucode_ind_seq.md
UCODE_IND_SEQ -- requirements
Module: ucode_ind_seq

Interface
REQ-001 SHALL have port clk  input  1  single core clock; all state updates on rising edge.
REQ-002 SHALL have port reset_l  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port ind_start_r  input  1  R-stage microcoded index op present; decode holds it high until accepted.
REQ-004 SHALL have port ind_mode_r  input  2  index mode: 00 RAW {op2,op3}; 01 BYTE_INC {0,op2}+1; 10 WORD_INC {op2,op3}+1; 11 PAIR (RAW, then WORD_INC).
REQ-005 SHALL have port iu_hold_e  input  1  E-stage hold; no capture in the index register when high.
REQ-006 SHALL have port iu_kill_e  input  1  pipeline flush; aborts any sequence in progress.
REQ-007 SHALL have port sm, sin  input  1 each  scan mode/scan in; reserved for scan insertion, no functional effect.
REQ-008 SHALL have port so  output  1  scan out; equals state register bit 0.
REQ-009 SHALL have port sel_wd_inc_r  output  1  combinational select to index register: 16-bit word vs zero-extended byte.
REQ-010 SHALL have port sel_offset_add1_r  output  1  combinational select to index register: incremented vs raw index.
REQ-011 SHALL have port ind_busy_r  output  1  sequence in progress; decode SHALL hold R-stage opcode bytes while high.
REQ-012 SHALL have port ind_valid_e  output  1  registered; index_byte1_e/2_e hold a valid index.
REQ-013 SHALL have port ind_num_e  output  2  registered ordinal of current index within op (0 first, 1 second).
REQ-014 SHALL have port ind_last_e  output  1  registered; current index is the final one of the op.

Function
REQ-015 SHALL implement FSM with states IDLE and PAIR2.
REQ-016 In IDLE with ind_start_r=0: selects 0/0, ind_busy_r=0.
REQ-017 In IDLE with ind_start_r=1: selects follow mode combinationally: RAW 0/0, BYTE_INC 0/1, WORD_INC 1/1, PAIR 0/0 (wd_inc/add1).
REQ-018 Capture SHALL occur when ind_start_r=1, iu_hold_e=0, iu_kill_e=0; zero added latency: index visible in E on the next cycle.
REQ-019 On capture of RAW/BYTE_INC/WORD_INC: state stays IDLE; next cycle ind_valid_e=1, ind_num_e=0, ind_last_e=1.
REQ-020 On capture of PAIR in IDLE: next state PAIR2; next cycle ind_valid_e=1, ind_num_e=0, ind_last_e=0.
REQ-021 In PAIR2: ind_busy_r=1, selects 1/1 regardless of ind_start_r/ind_mode_r; if iu_hold_e=0 capture, next state IDLE, next cycle ind_num_e=1, ind_last_e=1.
REQ-022 Any state with iu_hold_e=1 and iu_kill_e=0: state, ind_valid_e, ind_num_e, ind_last_e SHALL hold; start not accepted.
REQ-023 iu_kill_e=1: next state IDLE, ind_valid_e=0, ind_num_e=0, ind_last_e=0; overrides hold and start in the same cycle.
REQ-024 Cycle with no capture, no hold, no kill: ind_valid_e SHALL clear to 0 next cycle.
REQ-025 New ind_start_r in PAIR2 SHALL be ignored until IDLE is reached; back-to-back single ops in IDLE SHALL capture every unheld cycle.
REQ-026 Increment wrap (0xFFFF+1=0x0000) is owned by the index register; this block adds no width checks.

Reset
REQ-027 reset_l=0 at a rising edge: state IDLE, ind_valid_e=0, ind_num_e=0, ind_last_e=0, so=0.
REQ-028 While reset_l=0: sel_wd_inc_r=0, sel_offset_add1_r=0, ind_busy_r=0 combinationally; reset mid-PAIR abandons the second index.

Structure
REQ-029 Mode encodings (RAW/BYTE_INC/WORD_INC/PAIR) and state encodings SHALL live in the shared ucode defines header.
REQ-030 State and output flops SHALL use the codebase synchronous reset/enable flop cells; no further sub-module.

Verification
REQ-031 RAW, op2=0x12 op3=0x34, no hold -> selects 0/0; next cycle index=0x1234, valid=1, num=0, last=1.
REQ-032 BYTE_INC op2=0xFF -> selects 0/1; index=0x0100, last=1.
REQ-033 PAIR op2/op3=0x00FF, no hold -> cycle1 index=0x00FF last=0 busy=1; cycle2 index=0x0100 num=1 last=1; then IDLE, busy=0.
REQ-034 PAIR with iu_hold_e=1 two cycles in PAIR2 -> state/valid/num held, busy=1; second index captured on first unheld cycle.
REQ-035 PAIR, iu_kill_e=1 in PAIR2 -> next cycle IDLE, valid=0, busy=0; following RAW start captured normally.
REQ-036 reset_l=0 in PAIR2 with hold=1 -> next cycle IDLE, all registered outputs 0, selects 0/0.
